// File: rtl/adc_trig_capture_ctrl.sv
// Triggered two-channel ADC capture sequencer writing a circular window in DMEM port 2.
// Keeps a programmable pre-trigger history, evaluates a threshold/edge trigger, then finishes post-trigger capture.
module adc_trig_capture_ctrl #(
    parameter int                    ADDR_WIDTH = 13,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 13'h800,
    parameter int                    RING_AW    = 11
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [31:0]           adc_sample_i,
    input  logic                  adc_vld_i,
    input  logic                  csr_arm_i,
    input  logic                  csr_abort_i,
    input  logic [RING_AW-1:0]    cfg_len_i,
    input  logic [RING_AW-1:0]    cfg_pre_i,
    input  logic [11:0]           cfg_thresh_i,
    input  logic                  cfg_src_i,
    input  logic                  cfg_edge_i,
    input  logic                  cfg_force_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [RING_AW-1:0]    trig_idx_o,
    output logic [1:0]            state_o
);

    localparam int LW = RING_AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        ARMED = 2'd2,
        POST  = 2'd3
    } state_t;

    // A programmed length of zero selects the full 2^RING_AW ring.
    function automatic logic [LW-1:0] ring_len(input logic [RING_AW-1:0] len);
        logic [LW-1:0] r;
        if (len == '0) begin
            r          = '0;
            r[RING_AW] = 1'b1;
        end else begin
            r = {1'b0, len};
        end
        return r;
    endfunction

    function automatic logic [RING_AW-1:0] clamp_pre(input logic [RING_AW-1:0] pre,
                                                     input logic [LW-1:0]      len);
        logic [LW-1:0] lim;
        lim = len - LW'(1);
        if ({1'b0, pre} > lim) return lim[RING_AW-1:0];
        return pre;
    endfunction

    function automatic logic edge_hit(input logic [11:0] prev, input logic prev_ok,
                                      input logic [11:0] cur, input logic [11:0] th,
                                      input logic fall);
        if (!prev_ok) return 1'b0;
        if (fall) return (prev >= th) && (cur < th);
        return (prev < th) && (cur >= th);
    endfunction

    state_t              state_q;
    logic                arm_q;
    logic [LW-1:0]       len_q;
    logic [RING_AW-1:0]  pre_q;
    logic [11:0]         thresh_q;
    logic                src_q;
    logic                edge_q;
    logic [RING_AW-1:0]  idx_q;
    logic [LW-1:0]       cnt_q;
    logic [11:0]         prev_q;
    logic                prev_vld_q;
    logic                done_q;
    logic [RING_AW-1:0]  trig_idx_q;
    logic                vld_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [31:0]         data_p1;

    logic                accept;
    logic                abort;
    logic                arm_ok;
    logic                trig;
    logic [11:0]         cur;
    logic [RING_AW-1:0]  idx_next;
    logic [LW-1:0]       len_new;
    logic [RING_AW-1:0]  pre_new;
    logic [LW-1:0]       post_rem;

    assign accept   = adc_vld_i && (state_q != IDLE);
    assign abort    = csr_abort_i && (state_q != IDLE);
    assign arm_ok   = (state_q == IDLE) && csr_arm_i && !arm_q && !csr_abort_i;
    assign cur      = src_q ? adc_sample_i[27:16] : adc_sample_i[11:0];
    assign idx_next = ({1'b0, idx_q} == len_q - LW'(1)) ? '0 : idx_q + RING_AW'(1);
    assign len_new  = ring_len(cfg_len_i);
    assign pre_new  = clamp_pre(cfg_pre_i, len_new);
    assign post_rem = len_q - {1'b0, pre_q} - LW'(1);
    assign trig     = (state_q == ARMED) && accept &&
                      (cfg_force_i || edge_hit(prev_q, prev_vld_q, cur, thresh_q, edge_q));

    // Control, sequencing and the registered write port
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            arm_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            prev_vld_q <= 1'b0;
            done_q     <= 1'b0;
            trig_idx_q <= '0;
            vld_p1     <= 1'b0;
            addr_p1    <= '0;
            data_p1    <= '0;
        end else begin
            arm_q  <= csr_arm_i;
            vld_p1 <= accept && !abort;
            if (accept && !abort) begin
                addr_p1 <= BASE_ADDR + ADDR_WIDTH'(idx_q);
                data_p1 <= adc_sample_i;
                idx_q   <= idx_next;
            end
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (arm_ok) begin
                            done_q     <= 1'b0;
                            idx_q      <= '0;
                            prev_vld_q <= 1'b0;
                            cnt_q      <= {1'b0, pre_new};
                            state_q    <= (pre_new != '0) ? PRE : ARMED;
                        end
                    end
                    PRE: begin
                        if (accept) begin
                            prev_vld_q <= 1'b1;
                            cnt_q      <= cnt_q - LW'(1);
                            if (cnt_q == LW'(1)) state_q <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (accept) prev_vld_q <= 1'b1;
                        if (trig) begin
                            trig_idx_q <= idx_q;
                            cnt_q      <= post_rem;
                            if (post_rem == '0) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= POST;
                            end
                        end
                    end
                    POST: begin
                        if (accept) begin
                            cnt_q <= cnt_q - LW'(1);
                            if (cnt_q == LW'(1)) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Configuration snapshot and trigger history; data only, no reset needed
    always_ff @(posedge sys_clk) begin
        if (arm_ok) begin
            len_q    <= len_new;
            pre_q    <= pre_new;
            thresh_q <= cfg_thresh_i;
            src_q    <= cfg_src_i;
            edge_q   <= cfg_edge_i;
        end
        if (accept) prev_q <= cur;
    end

    assign mem_we_o   = vld_p1;
    assign mem_addr_o = addr_p1;
    assign mem_data_o = data_p1;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign trig_idx_o = trig_idx_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_adc_trig_capture_ctrl.sv
// Scoreboard bench for adc_trig_capture_ctrl: expected DMEM writes are queued as samples are driven
// and matched against mem_we_o/mem_addr_o/mem_data_o/done_o on the falling edge.
module tb_adc_trig_capture_ctrl;

    localparam int          AW   = 13;
    localparam logic [12:0] BASE = 13'h800;
    localparam int          RAW  = 11;

    logic            sys_clk;
    logic            sys_rst;
    logic [31:0]     adc_sample_i;
    logic            adc_vld_i;
    logic            csr_arm_i;
    logic            csr_abort_i;
    logic [RAW-1:0]  cfg_len_i;
    logic [RAW-1:0]  cfg_pre_i;
    logic [11:0]     cfg_thresh_i;
    logic            cfg_src_i;
    logic            cfg_edge_i;
    logic            cfg_force_i;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [31:0]     mem_data_o;
    logic            busy_o;
    logic            done_o;
    logic [RAW-1:0]  trig_idx_o;
    logic [1:0]      state_o;

    adc_trig_capture_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .RING_AW(RAW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .adc_sample_i(adc_sample_i), .adc_vld_i(adc_vld_i),
        .csr_arm_i(csr_arm_i), .csr_abort_i(csr_abort_i),
        .cfg_len_i(cfg_len_i), .cfg_pre_i(cfg_pre_i), .cfg_thresh_i(cfg_thresh_i),
        .cfg_src_i(cfg_src_i), .cfg_edge_i(cfg_edge_i), .cfg_force_i(cfg_force_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .busy_o(busy_o), .done_o(done_o), .trig_idx_o(trig_idx_o), .state_o(state_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [12:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_writes = 0;
    int  w0;
    int  k;
    logic [11:0] seq2 [8];
    logic [31:0] d;
    logic        v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge sys_clk) begin
        if (mem_we_o === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_we_o), 32'd0);
            end else begin
                mon_w = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr_o), 32'(mon_w.addr));
                check("wr_data", mem_data_o, mon_w.data);
                check("wr_done", 32'(done_o), 32'(mon_w.last));
            end
        end
    end

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // Drive one cycle; queue the expected write when sample index k falls inside the capture.
    task automatic send(input logic [31:0] s, input logic vl, input int kk, input int total, input int len);
        wr_t e;
        logic want;
        want = vl && (kk < total);
        adc_sample_i = s;
        adc_vld_i    = vl;
        if (want) begin
            e.addr = BASE + 13'(kk % len);
            e.data = s;
            e.last = (kk == total - 1);
            exp_q.push_back(e);
        end
        tick;
        check(want ? "wr_latency" : "no_write", 32'(mem_we_o), 32'(want));
    endtask

    task automatic arm(input int len_cfg, input int pre_cfg, input logic [11:0] th,
                       input logic src, input logic edg, input logic [1:0] exp_state);
        cfg_len_i    = RAW'(len_cfg);
        cfg_pre_i    = RAW'(pre_cfg);
        cfg_thresh_i = th;
        cfg_src_i    = src;
        cfg_edge_i   = edg;
        adc_vld_i    = 1'b0;
        csr_arm_i    = 1'b1;
        tick;
        csr_arm_i    = 1'b0;
        check("arm_state", 32'(state_o), 32'(exp_state));
        check("arm_done_clr", 32'(done_o), 32'd0);
        w0 = n_writes;
    endtask

    task automatic finish_cap(input int exp_trig, input int exp_writes);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(n_writes - w0), 32'(exp_writes));
        check("trig_idx", 32'(trig_idx_o), 32'(exp_trig));
        check("done_set", 32'(done_o), 32'd1);
        check("state_idle", 32'(state_o), 32'd0);
        check("busy_low", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; adc_sample_i = '0; adc_vld_i = 1'b0; csr_arm_i = 1'b0;
        csr_abort_i = 1'b0; cfg_len_i = '0; cfg_pre_i = '0; cfg_thresh_i = '0;
        cfg_src_i = 1'b0; cfg_edge_i = 1'b0; cfg_force_i = 1'b0;
        tick; tick;
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_trig", 32'(trig_idx_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        sys_rst = 1'b0;
        tick;

        // Rising trigger with pre-trigger history and ring wrap
        arm(8, 3, 12'h800, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 12; i++) send(32'h400 + 32'(i) * 32'h100, 1'b1, i, 9, 8);
        finish_cap(4, 9);

        // Falling edge on ch1, no pre-trigger; ch0 would trigger earlier if selected
        seq2 = '{12'h200, 12'h180, 12'h0F0, 12'h050, 12'h010, 12'h000, 12'h000, 12'h000};
        arm(4, 0, 12'h100, 1'b1, 1'b1, 2'd2);
        for (int i = 0; i < 8; i++) begin
            d = {4'h0, seq2[i], 4'h0, (i == 0) ? 12'h200 : 12'h050};
            send(d, 1'b1, i, 6, 4);
        end
        finish_cap(2, 6);

        // Forced trigger on the 10th sample
        arm(16, 4, 12'hFFF, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 24; i++) begin
            cfg_force_i = (i == 9);
            send(32'(i), 1'b1, i, 21, 16);
        end
        cfg_force_i = 1'b0;
        finish_cap(9, 21);

        // Abort while armed, then a normal re-arm
        arm(8, 2, 12'hFFF, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 5; i++) send(32'(i), 1'b1, i, 100, 8);
        check("abort_pre_state", 32'(state_o), 32'd2);
        csr_abort_i = 1'b1;
        send(32'd5, 1'b1, 5, 0, 8);
        csr_abort_i = 1'b0;
        check("abort_state", 32'(state_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        for (int i = 0; i < 3; i++) send(32'(6 + i), 1'b1, 0, 0, 8);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        check("abort_writes", 32'(n_writes - w0), 32'd5);
        arm(4, 1, 12'h800, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 6; i++) send(32'h100 + 32'(i) * 32'h800, 1'b1, i, 4, 4);
        finish_cap(1, 4);

        // vld gaps and an ignored arm pulse during PRE
        arm(8, 4, 12'h800, 1'b0, 1'b0, 2'd1);
        k = 0;
        for (int i = 0; k < 11; i++) begin
            v = !(i == 1 || i == 2 || i == 8);
            csr_arm_i = (i == 2);
            d = v ? ((k < 5) ? 32'h100 + 32'(k) : 32'h900) : 32'h0;
            send(d, v, k, 9, 8);
            if (i == 2) check("arm_ignored", 32'(state_o), 32'd1);
            if (v) k++;
        end
        csr_arm_i = 1'b0;
        finish_cap(5, 9);

        // Reset in the middle of POST
        arm(8, 2, 12'h800, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 5; i++) send((i < 3) ? 32'h100 : 32'h900, 1'b1, i, 100, 8);
        check("in_post", 32'(state_o), 32'd3);
        sys_rst = 1'b1;
        send(32'h900, 1'b1, 5, 0, 8);
        sys_rst = 1'b0;
        check("mrst_addr", 32'(mem_addr_o), 32'd0);
        check("mrst_data", mem_data_o, 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_done", 32'(done_o), 32'd0);
        check("mrst_trig", 32'(trig_idx_o), 32'd0);
        check("mrst_state", 32'(state_o), 32'd0);
        for (int i = 0; i < 2; i++) send(32'h900, 1'b1, 0, 0, 8);
        check("mrst_queue", 32'(exp_q.size()), 32'd0);

        // len = 0 and pre clamped to L-1: trigger sample is the last write
        arm(0, 2047, 12'hFFF, 1'b0, 1'b0, 2'd1);
        cfg_force_i = 1'b1;
        for (int i = 0; i < 2050; i++) begin
            send(32'(i & 32'hFFF), 1'b1, i, 2048, 2048);
            if (i == 2045) check("clamp_still_pre", 32'(state_o), 32'd1);
            if (i == 2046) check("clamp_armed", 32'(state_o), 32'd2);
        end
        cfg_force_i = 1'b0;
        finish_cap(2047, 2048);

        tick;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_trig_capture_ctrl.md
Name: adc_trig_capture_ctrl

Overview:
- Triggered ADC capture sequencer that replaces free-running capture into the DMEM ADC window.
- Streams packed two-channel ADC samples into a circular region of DMEM port 2 (ADC/DMA port).
- Evaluates a threshold/edge trigger on a selected channel, keeps a programmable number of pre-trigger samples, then completes post-trigger capture.
- Configured and polled by the CPU through CSR fields; reports the ring index of the trigger sample.

Parameters:
- ADDR_WIDTH, 13, DMEM word-address width of port 2
- BASE_ADDR, 13'h800, first DMEM word of the capture window
- RING_AW, 11, ring index width (max ring length 2048 words)

Ports:
- sys_clk  in  1  system clock; the only clock
- sys_rst  in  1  synchronous reset, active-high
- adc_sample_i  in  32  packed sample: ch0 in [11:0], ch1 in [27:16], other bits zero
- adc_vld_i  in  1  sample valid qualifier
- csr_arm_i  in  1  CSR arm level; a rising edge starts a capture
- csr_abort_i  in  1  level; forces IDLE
- cfg_len_i  in  RING_AW  ring length in words; 0 means 2048
- cfg_pre_i  in  RING_AW  number of pre-trigger samples
- cfg_thresh_i  in  12  unsigned trigger threshold
- cfg_src_i  in  1  trigger channel: 0 = ch0, 1 = ch1
- cfg_edge_i  in  1  trigger edge: 0 = rising, 1 = falling
- cfg_force_i  in  1  level; immediate trigger while ARMED
- mem_we_o  out  1  DMEM port-2 write enable
- mem_addr_o  out  ADDR_WIDTH  BASE_ADDR + ring index
- mem_data_o  out  32  sample written
- busy_o  out  1  high in PRE, ARMED, POST
- done_o  out  1  sticky capture-complete flag
- trig_idx_o  out  RING_AW  ring index of the trigger sample
- state_o  out  2  IDLE = 0, PRE = 1, ARMED = 2, POST = 3

Behaviour:
- Reset values: all outputs 0 and state IDLE. Reset is honoured in any state, including mid-capture; no write is issued in the cycle after reset.
- Arm detection:
  - Arm event = csr_arm_i high while its registered copy is low.
  - Accepted only in IDLE. An arm event in any other state is ignored.
- On an accepted arm event:
  - Latch len, pre, thresh, src and edge.
  - Set L = (cfg_len_i == 0) ? 2048 : cfg_len_i.
  - Set P = min(cfg_pre_i, L-1).
  - Clear done_o and the ring index. Invalidate the previous-sample register.
  - Next state is PRE if P > 0, otherwise ARMED.
- Sample acceptance:
  - A sample is accepted in PRE, ARMED or POST when adc_vld_i = 1.
  - An accepted sample in cycle N produces mem_we_o = 1 in cycle N+1, with that cycle's ring address and data. Latency is exactly 1 cycle.
  - mem_we_o is 0 in every other cycle.
- Ring index: increments per accepted sample and wraps from L-1 to 0.
- PRE state:
  - Counts accepted samples.
  - After P samples have been accepted, go to ARMED. The P-th sample itself is not evaluated for a trigger.
  - The first ARMED comparison still uses the last PRE sample as the previous sample.
- ARMED state:
  - Writes continue and overwrite the oldest ring entries.
  - Trigger on an accepted sample with value cur (selected channel) and previous value prev:
    - rising: prev valid, prev < thresh, and cur >= thresh
    - falling: prev valid, prev >= thresh, and cur < thresh
    - or cfg_force_i = 1 (force needs no prev)
  - The trigger sample is written. trig_idx_o is set to its ring index. Go to POST with remaining = L - P - 1.
  - If remaining = 0, go directly to IDLE and set done_o.
- POST state:
  - Each accepted sample decrements remaining.
  - The sample that brings remaining to 0 is the last write. In that same cycle the state goes to IDLE.
  - done_o rises in the cycle after the state goes to IDLE, coincident with the final mem_we_o.
- Completed buffer contents: the oldest pre-trigger sample is at (trig_idx - P) mod L; the newest sample is at (trig_idx + L - P - 1) mod L.
- Abort:
  - csr_abort_i in any busy state goes to IDLE next cycle.
  - An accepted sample in the abort cycle is dropped (no write follows).
  - done_o stays 0.
  - Abort has priority over an arm event and over a trigger in the same cycle.
- Gaps in adc_vld_i stall all counters and the trigger evaluator. No writes occur during gaps.
- done_o stays high until the next accepted arm event or reset.

Test Plan:
- Trigger with pre-trigger and wrap:
  - Setup: L = 8, P = 3, rising edge, thresh = 0x800, ch0 ramp 0x400, 0x500, … (step 0x100, vld always 1).
  - Required: writes 0x400..0x700 to 0x800..0x803; trigger on 0x800 with trig_idx = 4; 0x900..0xB00 to 0x805..0x807; 0xC00 to 0x800.
  - Required: done_o rises with the final write; exactly 9 writes in total.
- No pre-trigger, falling edge:
  - Setup: P = 0, L = 4, falling edge, src = ch1, thresh = 0x100, ch1 sequence 0x200, 0x180, 0x0F0, 0x050, 0x010, 0x000.
  - Required: trigger on 0x0F0 at idx 2; writes continue at idx 3, 0, 1; done_o set.
- Force trigger:
  - Setup: L = 16, P = 4, threshold never crossed, cfg_force_i = 1 asserted at the 10th accepted sample.
  - Required: trig_idx_o = 9; 11 more writes; done_o set.
- Abort:
  - Stimulus: assert csr_abort_i while ARMED.
  - Required: state_o = 0 next cycle; no further mem_we_o; done_o = 0.
  - Follow-up: a re-arm works normally.
- vld gaps and arm while busy:
  - Stimulus: toggle adc_vld_i 1-0-0-1 during PRE and pulse arm during PRE.
  - Required: writes only one cycle after each vld = 1; ring index is unaffected by the extra arm pulse.
- Reset mid-POST:
  - Stimulus: sys_rst = 1 for one cycle during POST.
  - Required: all outputs return to 0 on the next cycle; no write follows.
- Clamp and len = 0 corner:
  - Stimulus: cfg_pre_i = 2047, cfg_len_i = 0.
  - Required: L = 2048, P = 2047; PRE lasts 2047 samples; done_o follows the trigger sample immediately.
